// File: rtl/hex_syscall_ctrl_pkg.sv
// Shared types and constants for the Hex SVC system-call sequencer.
package hex_syscall_ctrl_pkg;

  localparam int unsigned BYTE_WIDTH = 8;

  typedef logic [15:0] waddr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    SYS_EXIT  = 2'd0,
    SYS_WRITE = 2'd1,
    SYS_READ  = 2'd2
  } syscall_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_F_SP,
    S_F_A0,
    S_F_A1,
    S_LD_A1,
    S_OUT,
    S_IN,
    S_WR_RES,
    S_DONE,
    S_HALT,
    S_ERR
  } svc_state_t;

  localparam waddr_t SVC_SP_WADDR = 16'd1;
  localparam waddr_t SVC_ARG_OFS  = 16'd2;

endpackage

// File: rtl/hex_syscall_ctrl_if.sv
// Core / memory / host-stream signal bundle seen by the syscall sequencer.
interface hex_syscall_ctrl_if;
  import hex_syscall_ctrl_pkg::*;

  logic                    i_svc_valid;
  logic [31:0]             i_areg;
  logic                    o_svc_done;
  logic                    o_mem_en;
  logic                    o_mem_we;
  waddr_t                  o_mem_addr;
  word_t                   o_mem_wdata;
  word_t                   i_mem_rdata;
  logic                    o_out_valid;
  logic [BYTE_WIDTH-1:0]   o_out_data;
  logic [31:0]             o_out_stream;
  logic                    i_out_ready;
  logic                    i_in_valid;
  logic [BYTE_WIDTH-1:0]   i_in_data;
  logic                    o_in_ready;
  logic [31:0]             o_in_stream;
  logic                    o_exit;
  logic [31:0]             o_exit_code;
  logic                    o_error;

  modport master (
    input  i_svc_valid, i_areg, i_mem_rdata, i_out_ready, i_in_valid, i_in_data,
    output o_svc_done, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
           o_out_valid, o_out_data, o_out_stream, o_in_ready, o_in_stream,
           o_exit, o_exit_code, o_error
  );

  modport slave (
    output i_svc_valid, i_areg, i_mem_rdata, i_out_ready, i_in_valid, i_in_data,
    input  o_svc_done, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
           o_out_valid, o_out_data, o_out_stream, o_in_ready, o_in_stream,
           o_exit, o_exit_code, o_error
  );

endinterface

// File: rtl/hex_syscall_ctrl.sv
// Sequences SVC EXIT/WRITE/READ: fetches sp and arguments, runs the byte
// handshake, writes back any result, then pulses done to release the core.
module hex_syscall_ctrl
  import hex_syscall_ctrl_pkg::*;
#(
  parameter waddr_t SP_WADDR = SVC_SP_WADDR,
  parameter waddr_t ARG_OFS  = SVC_ARG_OFS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  hex_syscall_ctrl_if.master   bus
);

  svc_state_t            state_q;
  syscall_t              call_q;
  waddr_t                sp_q;
  word_t                 arg0_q;
  word_t                 arg1_q;
  logic [BYTE_WIDTH-1:0] byte_q;

  logic   mem_en, mem_we;
  waddr_t mem_addr;
  word_t  mem_wdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      call_q  <= SYS_EXIT;
      sp_q    <= '0;
      arg0_q  <= '0;
      arg1_q  <= '0;
      byte_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.i_svc_valid) begin
          call_q  <= syscall_t'(bus.i_areg[1:0]);
          state_q <= (bus.i_areg >= 32'd3) ? S_ERR : S_F_SP;
        end
        S_F_SP:  state_q <= S_F_A0;
        S_F_A0: begin
          sp_q    <= bus.i_mem_rdata[15:0];
          state_q <= S_F_A1;
        end
        S_F_A1: begin
          arg0_q <= bus.i_mem_rdata;
          case (call_q)
            SYS_EXIT: state_q <= S_HALT;
            SYS_READ: state_q <= S_IN;
            default:  state_q <= S_LD_A1;
          endcase
        end
        S_LD_A1: begin
          arg1_q  <= bus.i_mem_rdata;
          state_q <= S_OUT;
        end
        S_OUT: if (bus.i_out_ready) state_q <= S_DONE;
        S_IN: if (bus.i_in_valid) begin
          byte_q  <= bus.i_in_data;
          state_q <= S_WR_RES;
        end
        S_WR_RES: state_q <= S_DONE;
        S_DONE:   state_q <= S_IDLE;
        S_HALT:   state_q <= S_HALT;
        S_ERR:    state_q <= S_ERR;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // The first argument address is formed from the sp word still on the read
  // bus, so the argument fetch can be issued in the cycle sp arrives.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_F_SP: begin
        mem_en   = 1'b1;
        mem_addr = SP_WADDR;
      end
      S_F_A0: begin
        mem_en   = 1'b1;
        mem_addr = bus.i_mem_rdata[15:0] + ARG_OFS;
      end
      S_F_A1: if (call_q == SYS_WRITE) begin
        mem_en   = 1'b1;
        mem_addr = sp_q + ARG_OFS + 16'd1;
      end
      S_WR_RES: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q + ARG_OFS - 16'd1;
        mem_wdata = {{(32-BYTE_WIDTH){1'b0}}, byte_q};
      end
      default: ;
    endcase
  end

  assign bus.o_mem_en     = mem_en;
  assign bus.o_mem_we     = mem_we;
  assign bus.o_mem_addr   = mem_addr;
  assign bus.o_mem_wdata  = mem_wdata;
  assign bus.o_out_valid  = (state_q == S_OUT);
  assign bus.o_out_data   = (state_q == S_OUT) ? arg0_q[BYTE_WIDTH-1:0] : '0;
  assign bus.o_out_stream = (state_q == S_OUT) ? arg1_q : '0;
  assign bus.o_in_ready   = (state_q == S_IN);
  assign bus.o_in_stream  = (state_q == S_IN) ? arg0_q : '0;
  assign bus.o_svc_done   = (state_q == S_DONE);
  assign bus.o_exit       = (state_q == S_HALT);
  assign bus.o_exit_code  = (state_q == S_HALT) ? arg0_q : '0;
  assign bus.o_error      = (state_q == S_ERR);

endmodule

// File: tb/tb_hex_syscall_ctrl.sv
// Directed and randomized bench for hex_syscall_ctrl with a word-memory model
// and a stack-layout reference model of each syscall.
module tb_hex_syscall_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] mem [0:65535];
  int en_cnt = 0, wr_cnt = 0, done_cnt = 0, strm_cnt = 0;

  hex_syscall_ctrl_if bus ();

  hex_syscall_ctrl #(.SP_WADDR(16'd1), .ARG_OFS(16'd2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      en_cnt = en_cnt + 1;
      if (bus.o_mem_we) begin
        mem[bus.o_mem_addr] = bus.o_mem_wdata;
        wr_cnt = wr_cnt + 1;
      end
      bus.i_mem_rdata <= mem[bus.o_mem_addr];
    end
    if (bus.o_svc_done) done_cnt = done_cnt + 1;
    if (bus.o_out_valid || bus.o_in_ready) strm_cnt = strm_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_svc_valid = 1'b0;
    bus.i_areg      = '0;
    bus.i_out_ready = 1'b0;
    bus.i_in_valid  = 1'b0;
    bus.i_in_data   = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic any_out();
    return |{bus.o_svc_done, bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata,
             bus.o_out_valid, bus.o_out_data, bus.o_out_stream, bus.o_in_ready,
             bus.o_in_stream, bus.o_exit, bus.o_exit_code, bus.o_error};
  endfunction

  // Reference: sp = mem[1][15:0]; args at sp+2, sp+3; READ result lands at sp+1.
  task automatic run_rw(input string tag, input logic [31:0] areg, input int dly,
                        input logic [7:0] in_byte);
    logic [15:0] sp, res_addr;
    logic [31:0] a0, a1;
    int n, w0, d0;
    bit found;
    sp       = mem[1][15:0];
    a0       = mem[16'(sp + 16'd2)];
    a1       = mem[16'(sp + 16'd3)];
    res_addr = sp + 16'd1;
    w0 = wr_cnt;
    d0 = done_cnt;
    bus.i_areg      = areg;
    bus.i_svc_valid = 1'b1;
    bus.i_out_ready = (dly == 0);
    bus.i_in_valid  = 1'b0;
    n = 0;
    found = 0;
    while (n < 20 && !found) begin
      step();
      n++;
      if (bus.o_out_valid || bus.o_in_ready) found = 1;
    end
    chk({tag, "_latency"}, 32'(n), (areg == 32'd1) ? 32'd5 : 32'd4);
    if (areg == 32'd1) begin
      chk({tag, "_out_data"}, 32'(bus.o_out_data), 32'(a0[7:0]));
      chk({tag, "_out_stream"}, bus.o_out_stream, a1);
      for (int i = 0; i < dly; i++) begin
        step();
        chk({tag, "_out_hold"}, {31'b0, bus.o_out_valid}, 32'd1);
      end
      bus.i_out_ready = 1'b1;
      step();
      bus.i_out_ready = 1'b0;
    end else begin
      chk({tag, "_in_stream"}, bus.o_in_stream, a0);
      for (int i = 0; i < dly; i++) begin
        step();
        chk({tag, "_in_hold"}, {31'b0, bus.o_in_ready}, 32'd1);
      end
      bus.i_in_valid = 1'b1;
      bus.i_in_data  = in_byte;
      step();
      bus.i_in_valid = 1'b0;
      chk({tag, "_wr_en"}, {30'b0, bus.o_mem_en, bus.o_mem_we}, 32'd3);
      chk({tag, "_wr_addr"}, 32'(bus.o_mem_addr), 32'(res_addr));
      chk({tag, "_wr_data"}, bus.o_mem_wdata, {24'b0, in_byte});
      step();
    end
    chk({tag, "_done"}, {31'b0, bus.o_svc_done}, 32'd1);
    bus.i_svc_valid = 1'b0;
    step();
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    if (areg == 32'd1) begin
      chk({tag, "_no_write"}, 32'(wr_cnt - w0), 32'd0);
    end else begin
      chk({tag, "_one_write"}, 32'(wr_cnt - w0), 32'd1);
      chk({tag, "_mem_result"}, mem[res_addr], {24'b0, in_byte});
    end
  endtask

  initial begin
    int e0, s0, d0;
    logic [15:0] sp;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    clear_inputs();
    step();
    step();
    chk("reset_outputs", {31'b0, any_out()}, 32'd0);
    rst_n = 1'b1;
    step();

    // WRITE, sink always ready
    mem[1] = 32'h100; mem[16'h102] = 32'h41; mem[16'h103] = 32'd2;
    run_rw("write", 32'd1, 0, 8'h00);

    // READ with source delayed three cycles
    mem[1] = 32'h200; mem[16'h202] = 32'd0;
    run_rw("read_bp", 32'd2, 3, 8'h7A);

    // EXIT: sticky, ignores further calls
    do_reset();
    mem[1] = 32'h80; mem[16'h82] = 32'd5;
    d0 = done_cnt;
    bus.i_areg = 32'd0;
    bus.i_svc_valid = 1'b1;
    repeat (3) step();
    chk("exit_early", {31'b0, bus.o_exit}, 32'd0);
    step();
    chk("exit_flag", {31'b0, bus.o_exit}, 32'd1);
    chk("exit_code", bus.o_exit_code, 32'd5);
    bus.i_svc_valid = 1'b0;
    repeat (3) step();
    bus.i_areg = 32'd1;
    bus.i_svc_valid = 1'b1;
    repeat (8) step();
    chk("exit_sticky", {31'b0, bus.o_exit}, 32'd1);
    chk("exit_code_sticky", bus.o_exit_code, 32'd5);
    chk("exit_no_done", 32'(done_cnt - d0), 32'd0);

    // invalid syscall numbers
    for (int k = 0; k < 2; k++) begin
      do_reset();
      e0 = en_cnt; s0 = strm_cnt; d0 = done_cnt;
      bus.i_areg = (k == 0) ? 32'd3 : ($urandom | 32'h8000_0000);
      bus.i_svc_valid = 1'b1;
      step();
      chk("err_flag", {31'b0, bus.o_error}, 32'd1);
      bus.i_svc_valid = 1'b0;
      repeat (5) step();
      chk("err_sticky", {31'b0, bus.o_error}, 32'd1);
      chk("err_no_mem", 32'(en_cnt - e0), 32'd0);
      chk("err_no_stream", 32'(strm_cnt - s0), 32'd0);
      chk("err_no_done", 32'(done_cnt - d0), 32'd0);
    end

    // OUT stall with reset in the middle, then a clean WRITE
    do_reset();
    mem[1] = 32'h300; mem[16'h302] = 32'h5A; mem[16'h303] = 32'd9;
    bus.i_areg = 32'd1;
    bus.i_svc_valid = 1'b1;
    repeat (5) step();
    chk("stall_out_valid", {31'b0, bus.o_out_valid}, 32'd1);
    repeat (3) step();
    rst_n = 1'b0;
    bus.i_svc_valid = 1'b0;
    step();
    chk("stall_reset_outputs", {31'b0, any_out()}, 32'd0);
    rst_n = 1'b1;
    repeat (6) step();
    chk("stall_idle_quiet", {31'b0, any_out()}, 32'd0);
    run_rw("post_reset_write", 32'd1, 1, 8'h00);

    // sp wraparound on READ
    mem[1] = 32'hFFFF;
    run_rw("wrap_read", 32'd2, 0, 8'h11);
    chk("wrap_slot0", mem[0], 32'h11);

    // randomized WRITE/READ traffic
    for (int it = 0; it < 16; it++) begin
      sp = 16'($urandom_range(16'h0010, 16'hFFF0));
      mem[1] = {16'($urandom), sp};
      mem[16'(sp + 16'd2)] = $urandom;
      mem[16'(sp + 16'd3)] = $urandom;
      run_rw("rand", 32'($urandom_range(1, 2)), int'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_syscall_ctrl.md
Name: hex_syscall_ctrl

Overview:
- Sequences Hex `SVC` (OPR opcode 3) system calls on behalf of the processor core.
- While the core stalls, the block owns the memory port. It reads the stack pointer and arguments, performs EXIT/WRITE/READ over byte-stream handshakes, writes any result back to memory, then releases the core.
- Sits between the core, the word memory and the host I/O stream interface.

Parameters:
- SP_WADDR, 1, word address that holds the stack pointer.
- ARG_OFS, 2, word offset from sp to the first argument; the result slot is sp+ARG_OFS-1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_svc_valid  in  1  core has issued SVC; held until o_svc_done
- i_areg  in  32  syscall number (A register)
- o_svc_done  out  1  one-cycle pulse: syscall complete, core may advance
- o_mem_en  out  1  memory access this cycle
- o_mem_we  out  1  write enable
- o_mem_addr  out  16  word address (waddr_t)
- o_mem_wdata  out  32  write data
- i_mem_rdata  in  32  read data, valid the cycle after the read is issued
- o_out_valid  out  1  output byte valid
- o_out_data  out  8  output byte
- o_out_stream  out  32  output stream id
- i_out_ready  in  1  output sink ready
- i_in_valid  in  1  input byte valid
- i_in_data  in  8  input byte
- o_in_ready  out  1  block ready for an input byte
- o_in_stream  out  32  input stream id
- o_exit  out  1  program exited (sticky)
- o_exit_code  out  32  exit code
- o_error  out  1  invalid syscall (sticky)

Behaviour:
- Reset (i_rst_n=0 at a clock edge): go to IDLE. All outputs are 0 and internal registers are cleared.
  - Reset takes priority in every state, including mid-handshake.
  - No memory write is issued in the reset cycle.
- Memory and stream outputs decode combinationally from state and registers. A handshake completes on a clock edge where valid and ready are both 1.
- States are IDLE, F_SP, F_A0, F_A1, LD_A1, OUT, IN, WR_RES, DONE, HALT, ERR.
- IDLE: when i_svc_valid=1, latch i_areg.
  - i_areg ≥ 3: go to ERR.
  - Otherwise: go to F_SP.
- F_SP: read SP_WADDR. Go to F_A0.
- F_A0: sp = i_mem_rdata[15:0] (registered); read sp+ARG_OFS.
- F_A1: arg0 = i_mem_rdata (registered).
  - EXIT: go to HALT.
  - READ: go to IN, with no memory access.
  - WRITE: read sp+ARG_OFS+1, go to LD_A1.
- LD_A1: arg1 = i_mem_rdata. Go to OUT.
- OUT: o_out_valid=1, o_out_data=arg0[7:0], o_out_stream=arg1. On handshake go to DONE; otherwise hold with all outputs stable.
- IN: o_in_ready=1, o_in_stream=arg0. On handshake capture i_in_data and go to WR_RES.
- WR_RES: write {24'b0, byte} to sp+ARG_OFS-1. Go to DONE.
- DONE: o_svc_done=1 for exactly one cycle. Go to IDLE. The core deasserts i_svc_valid in the following cycle, so there is no retrigger.
- HALT: o_exit=1, o_exit_code=arg0. Terminal until reset; i_svc_valid is ignored; o_svc_done is never asserted.
- ERR: o_error=1. Terminal until reset; o_svc_done is never asserted.
- Address arithmetic is 16-bit modulo; wraparound is allowed (sp=0xFFFF, ARG_OFS=2 gives 0x0001).
- Latency, with accept at cycle T and sinks/sources always ready:
  - WRITE: byte out at T+5, o_svc_done at T+6.
  - READ: o_in_ready at T+4, memory write at T+5, o_svc_done at T+6.
  - EXIT: o_exit at T+4.
- Only one syscall is in flight at a time; no pipelining.

Decomposition:
- hex_pkg gains the following; the syscall_t enum is reused:
  - a syscall state enum (svc_state_t);
  - constants SVC_SP_WADDR and SVC_ARG_OFS;
  - the byte width constant BYTE_WIDTH=8.
- No sub-module. The FSM and argument registers form a single module; memory-model reuse stays in the bench.

Test Plan:
- WRITE: mem[1]=0x100, mem[0x102]=0x41, mem[0x103]=2, areg=1, i_out_ready held 1 → o_out_data=0x41 and o_out_stream=2 at T+5; o_svc_done pulse at T+6; no memory write.
- READ with backpressure: mem[1]=0x200, mem[0x202]=0, areg=2, i_in_valid delayed 3 cycles, then data 0x7A → o_in_ready held until the handshake; mem[0x201]=0x0000007A; single o_svc_done pulse.
- EXIT: mem[1]=0x80, mem[0x82]=5, areg=0 → o_exit=1 and o_exit_code=5 at T+4, both stay high; a further i_svc_valid is ignored; o_svc_done never pulses.
- Invalid syscall: areg=3 → o_error=1 at T+1, sticky; no memory access; no stream activity.
- OUT stall plus mid-syscall reset: i_out_ready=0 for 10 cycles, with reset asserted on cycle 4 → all outputs 0 the next cycle, state IDLE; a subsequent WRITE completes normally.
- Wraparound: mem[1]=0xFFFF, READ, input byte 0x11 → stream read from 0x0001; result written to 0x0000.
